// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types: the response code and the read-master state encoding.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10,
    ST_RESP = 2'b11
  } rd_state_t;

endpackage

// File: rtl/axi4_lite_read_master_if.sv
// AXI4-Lite read channels (AR + R) between a read master and a read slave.
interface axi4_lite_read_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] M_AXI_ARADDR;
  logic                  M_AXI_ARVALID;
  logic                  M_AXI_ARREADY;
  logic [DATA_WIDTH-1:0] M_AXI_RDATA;
  logic [1:0]            M_AXI_RRESP;
  logic                  M_AXI_RVALID;
  logic                  M_AXI_RREADY;

  modport master (
    output M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
    input  M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );

  modport slave (
    input  M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
    output M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );
endinterface

// File: rtl/axi4_lite_read_master.sv
// Single-outstanding AXI4-Lite read master. Aligned requests go out on AR/R;
// misaligned requests complete locally with read_misaligned set.
module axi4_lite_read_master
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_req,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic                  req_ready,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic [1:0]            read_resp,
  output logic                  read_misaligned,
  output logic                  read_done,
  axi4_lite_read_master_if.master m_axi
);

  // Number of byte-offset bits that must be zero for a full-width access.
  localparam int OFS_W = $clog2(DATA_WIDTH / 8);

  function automatic logic addr_aligned(input logic [OFS_W-1:0] ofs);
    return ofs == '0;
  endfunction

  rd_state_t             state;
  rd_state_t             state_nxt;
  logic                  addr_ok;
  logic                  misaligned_r;
  logic [ADDR_WIDTH-1:0] araddr_r;

  assign addr_ok         = addr_aligned(read_addr[OFS_W-1:0]);
  assign read_misaligned = misaligned_r;
  assign m_axi.M_AXI_ARADDR = araddr_r;

  // State register; reset abandons any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and Moore decode of all handshake outputs.
  always_comb begin
    state_nxt           = state;
    req_ready           = 1'b0;
    read_done           = 1'b0;
    m_axi.M_AXI_ARVALID = 1'b0;
    m_axi.M_AXI_RREADY  = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (read_req) state_nxt = addr_ok ? ST_ADDR : ST_RESP;
      end
      ST_ADDR: begin
        m_axi.M_AXI_ARVALID = 1'b1;
        if (m_axi.M_AXI_ARREADY) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        m_axi.M_AXI_RREADY = 1'b1;
        if (m_axi.M_AXI_RVALID) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        read_done = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Latch the address on acceptance; capture the result on local or bus completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      araddr_r     <= '0;
      read_data    <= '0;
      read_resp    <= RESP_OKAY;
      misaligned_r <= 1'b0;
    end else begin
      if (state == ST_IDLE && read_req) begin
        if (addr_ok) begin
          araddr_r <= read_addr;
        end else begin
          misaligned_r <= 1'b1;
          read_data    <= '0;
          read_resp    <= RESP_OKAY;
        end
      end
      if (state == ST_DATA && m_axi.M_AXI_RVALID) begin
        read_data    <= m_axi.M_AXI_RDATA;
        read_resp    <= m_axi.M_AXI_RRESP;
        misaligned_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi4_lite_read_master.sv
// Bench for axi4_lite_read_master: table of read transactions against a
// programmable-wait slave model, plus back-to-back and mid-transaction reset.
module tb_axi4_lite_read_master;
  import axi4_lite_pkg::*;

  typedef struct {
    logic [31:0] addr;
    int          ar_wait;
    int          r_wait;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    logic        exp_mis;
    int          exp_lat;
  } vec_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        mis;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        read_req;
  logic [31:0] read_addr;
  logic        req_ready;
  logic [31:0] read_data;
  logic [1:0]  read_resp;
  logic        read_misaligned;
  logic        read_done;

  axi4_lite_read_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  axi4_lite_read_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .read_req        (read_req),
    .read_addr       (read_addr),
    .req_ready       (req_ready),
    .read_data       (read_data),
    .read_resp       (read_resp),
    .read_misaligned (read_misaligned),
    .read_done       (read_done),
    .m_axi           (axi.master)
  );

  int errors = 0;
  int checks = 0;
  exp_t exp_q[$];

  // slave model configuration and observation counters
  int          cfg_ar_wait = 0;
  int          cfg_r_wait  = 0;
  logic [31:0] cfg_rdata   = '0;
  logic [1:0]  cfg_rresp   = 2'b00;
  int          ar_hs = 0;
  int          r_hs  = 0;
  int          arvalid_cycles = 0;
  int          araddr_moved   = 0;
  logic [31:0] hs_addr = '0;
  logic [31:0] ar_prev = '0;
  int          ar_cnt = 0;
  int          r_cnt  = 0;
  bit          r_pending = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Slave model: updates at the falling edge so the master sees stable inputs at the rising edge.
  always @(negedge clk) begin
    if (rst) begin
      axi.M_AXI_ARREADY = 1'b0;
      axi.M_AXI_RVALID  = 1'b0;
      axi.M_AXI_RDATA   = '0;
      axi.M_AXI_RRESP   = 2'b00;
      r_pending = 0;
      ar_cnt = 0;
      r_cnt  = 0;
    end else begin
      if (r_pending) begin
        axi.M_AXI_RVALID = (r_cnt >= cfg_r_wait);
        r_cnt++;
        if (axi.M_AXI_RVALID) begin
          axi.M_AXI_RDATA = cfg_rdata;
          axi.M_AXI_RRESP = cfg_rresp;
        end
        if (axi.M_AXI_RVALID && axi.M_AXI_RREADY) begin
          r_hs++;
          r_pending = 0;
          r_cnt = 0;
        end
      end else begin
        axi.M_AXI_RVALID = 1'b0;
      end
      if (axi.M_AXI_ARVALID) begin
        arvalid_cycles++;
        if (ar_cnt > 0 && axi.M_AXI_ARADDR !== ar_prev) araddr_moved++;
        ar_prev = axi.M_AXI_ARADDR;
        axi.M_AXI_ARREADY = (ar_cnt >= cfg_ar_wait);
        ar_cnt++;
        if (axi.M_AXI_ARREADY) begin
          ar_hs++;
          hs_addr = axi.M_AXI_ARADDR;
          r_pending = 1;
          r_cnt = 0;
          ar_cnt = 0;
        end
      end else begin
        axi.M_AXI_ARREADY = 1'b0;
        ar_cnt = 0;
      end
    end
  end

  // Scoreboard: every completion pops the oldest expected result.
  always @(negedge clk) begin
    if (!rst && read_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got read_done=1 expected no completion");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("read_data", 64'(read_data), 64'(e.data));
        check("read_resp", 64'(read_resp), 64'(e.resp));
        check("read_misaligned", 64'(read_misaligned), 64'(e.mis));
      end
    end
  end

  function automatic vec_t mkv(input logic [31:0] addr, input int arw, input int rw,
                               input logic [31:0] rdata, input logic [1:0] rresp,
                               input logic [31:0] ed, input logic [1:0] er,
                               input logic em, input int lat);
    vec_t v;
    v.addr = addr; v.ar_wait = arw; v.r_wait = rw; v.rdata = rdata; v.rresp = rresp;
    v.exp_data = ed; v.exp_resp = er; v.exp_mis = em; v.exp_lat = lat;
    return v;
  endfunction

  // Issue one request from a falling edge in idle; returns at a falling edge in idle.
  task automatic do_read(input vec_t v);
    int lat;
    bit seen;
    cfg_ar_wait = v.ar_wait; cfg_r_wait = v.r_wait;
    cfg_rdata = v.rdata; cfg_rresp = v.rresp;
    ar_hs = 0; r_hs = 0; arvalid_cycles = 0; araddr_moved = 0;
    exp_q.push_back('{data: v.exp_data, resp: v.exp_resp, mis: v.exp_mis});
    read_req = 1'b1;
    read_addr = v.addr;
    @(posedge clk);
    #1;
    read_req = 1'b0;
    read_addr = ~v.addr;
    lat = 0;
    seen = 0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) check("req_ready_busy", 64'(req_ready), 64'd0);
      if (read_done) begin
        lat = c;
        seen = 1;
      end
    end
    check("latency", 64'(lat), 64'(v.exp_lat));
    check("ar_handshakes", 64'(ar_hs), v.exp_mis ? 64'd0 : 64'd1);
    check("r_handshakes", 64'(r_hs), v.exp_mis ? 64'd0 : 64'd1);
    check("araddr_stable", 64'(araddr_moved), 64'd0);
    if (v.exp_mis) check("arvalid_cycles", 64'(arvalid_cycles), 64'd0);
    else           check("araddr", 64'(hs_addr), 64'(v.addr));
    @(negedge clk);
    check("req_ready_after", 64'(req_ready), 64'd1);
    check("read_data_held", 64'(read_data), 64'(v.exp_data));
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = mkv(32'h0000_0010, 0, 0, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 2'b00, 1'b0, 3);
    vecs[1] = mkv(32'h0000_0020, 3, 2, 32'hCAFE_F00D, 2'b00, 32'hCAFE_F00D, 2'b00, 1'b0, 8);
    vecs[2] = mkv(32'h0000_0013, 0, 0, 32'h5555_5555, 2'b11, 32'h0000_0000, 2'b00, 1'b1, 1);
    vecs[3] = mkv(32'h0000_0024, 0, 0, 32'h0000_1234, 2'b10, 32'h0000_1234, 2'b10, 1'b0, 3);
    vecs[4] = mkv(32'h0000_0030, 1, 0, 32'h0000_A5A5, 2'b11, 32'h0000_A5A5, 2'b11, 1'b0, 4);
    vecs[5] = mkv(32'h0000_0002, 0, 0, 32'h7777_7777, 2'b00, 32'h0000_0000, 2'b00, 1'b1, 1);
    vecs[6] = mkv(32'hFFFF_FFFC, 0, 1, 32'hFFFF_FFFF, 2'b01, 32'hFFFF_FFFF, 2'b01, 1'b0, 4);

    rst = 1'b1;
    read_req = 1'b0;
    read_addr = '0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_arvalid", 64'(axi.M_AXI_ARVALID), 64'd0);
    check("rst_rready", 64'(axi.M_AXI_RREADY), 64'd0);
    check("rst_read_done", 64'(read_done), 64'd0);
    check("rst_araddr", 64'(axi.M_AXI_ARADDR), 64'd0);
    check("rst_read_data", 64'(read_data), 64'd0);
    check("rst_read_resp", 64'(read_resp), 64'd0);
    check("rst_misaligned", 64'(read_misaligned), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) do_read(vecs[i]);

    // read_req held high across two addresses: second accepted four cycles later
    begin
      int first_ready;
      int done_cnt;
      int done2;
      cfg_ar_wait = 0; cfg_r_wait = 0; cfg_rdata = 32'h1111_2222; cfg_rresp = 2'b00;
      ar_hs = 0; r_hs = 0;
      exp_q.push_back('{data: 32'h1111_2222, resp: 2'b00, mis: 1'b0});
      exp_q.push_back('{data: 32'h1111_2222, resp: 2'b00, mis: 1'b0});
      read_req = 1'b1;
      read_addr = 32'h0000_0100;
      @(posedge clk);
      #1 read_addr = 32'h0000_0200;
      first_ready = 0; done_cnt = 0; done2 = 0;
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        if (req_ready && first_ready == 0) first_ready = c;
        if (read_done) begin
          done_cnt++;
          if (done_cnt == 2) done2 = c;
        end
        if (c == 5) read_req = 1'b0;
      end
      check("b2b_first_ready", 64'(first_ready), 64'd4);
      check("b2b_done_count", 64'(done_cnt), 64'd2);
      check("b2b_second_done", 64'(done2), 64'd7);
      check("b2b_ar_handshakes", 64'(ar_hs), 64'd2);
      check("b2b_second_addr", 64'(hs_addr), 64'h200);
    end

    // reset while the slave stalls the R channel
    cfg_ar_wait = 0; cfg_r_wait = 30; cfg_rdata = 32'h9999_9999; cfg_rresp = 2'b00;
    read_req = 1'b1;
    read_addr = 32'h0000_0040;
    @(posedge clk);
    #1 read_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_rready_before", 64'(axi.M_AXI_RREADY), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rready", 64'(axi.M_AXI_RREADY), 64'd0);
    check("mid_arvalid", 64'(axi.M_AXI_ARVALID), 64'd0);
    check("mid_req_ready", 64'(req_ready), 64'd1);
    check("mid_araddr", 64'(axi.M_AXI_ARADDR), 64'd0);
    check("mid_read_data", 64'(read_data), 64'd0);
    check("mid_read_resp", 64'(read_resp), 64'd0);
    check("mid_misaligned", 64'(read_misaligned), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_read(mkv(32'h0000_0044, 0, 0, 32'h0BAD_CAFE, 2'b00, 32'h0BAD_CAFE, 2'b00, 1'b0, 3));

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test expected completion within budget");
    $fatal(1, "timeout");
  end

endmodule
